// File: rtl/parity_fifo_pkg.sv
// Shared helpers for the parity FIFO: sizing rules and parity check.
// Parity is evaluated on a zero-extended word so one function serves all widths.
package fifo_pkg;

   localparam int MAX_W = 256;

   function automatic int addr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

   function automatic logic parity_ok(
      input logic [MAX_W-1:0] word,
      input logic             odd
   );
      return (^word) == odd;
   endfunction

endpackage

// File: rtl/parity_fifo_if.sv
// Valid/grant link carrying one parity-protected word per transfer.
// The master drives data and valid; the slave answers with grant.
interface parity_fifo_if #(
   parameter int DATA_WIDTH = 17
);

   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  grant;

   modport master (
      output data,
      output valid,
      input  grant
   );

   modport slave (
      input  data,
      input  valid,
      output grant
   );

endinterface

// File: rtl/parity_fifo_mem.sv
// FIFO storage array: synchronous write, asynchronous read at the head.
// No reset on the array; occupancy tracking alone decides what is valid.
module parity_fifo_mem #(
   parameter int DATA_WIDTH = 17,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [ADDR_W-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_W-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/parity_fifo.sv
// First-word fall-through FIFO with parity checks on write and read,
// threshold flags and a saturating parity error counter.
module parity_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 17,
   parameter int DEPTH      = 16,
   parameter bit PARITY_ODD = 1'b0,
   parameter bit DROP_BAD   = 1'b0,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   parity_fifo_if.slave             up_if,
   parity_fifo_if.master            dn_if,
   output logic                     par_err_out,
   output logic                     in_err,
   output logic [cnt_w(DEPTH)-1:0]  count,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [ERR_CNT_W-1:0]     err_cnt
);

   localparam int ADDR_W = addr_w(DEPTH);
   localparam int CNT_W  = cnt_w(DEPTH);

   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);

   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_depth_chk
      $error("parity_fifo: DEPTH must be a power of 2, >= 4");
   end

   logic [ADDR_W-1:0]     wptr_q, wptr_d;
   logic [ADDR_W-1:0]     rptr_q, rptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  in_err_q, in_err_d;
   logic [ERR_CNT_W-1:0]  err_q, err_d;
   logic [ERR_CNT_W:0]    err_sum;
   logic [1:0]            err_inc;
   logic [DATA_WIDTH-1:0] head;

   logic full, empty;
   logic push, pop;
   logic bad_in, bad_out;
   logic store;

   assign full  = (count_q == FULL_C);
   assign empty = (count_q == '0);

   // Handshake outputs come from count only, never from valid/grant inputs.
   assign up_if.grant = !full;
   assign dn_if.valid = !empty;
   assign dn_if.data  = head;

   assign push = up_if.valid && !full;
   assign pop  = !empty && dn_if.grant;

   assign bad_in  = !parity_ok(MAX_W'(up_if.data), PARITY_ODD);
   assign bad_out = !empty && !parity_ok(MAX_W'(head), PARITY_ODD);

   // A dropped word is still consumed upstream but never written.
   assign store = push && !(bad_in && DROP_BAD);

   parity_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (store),
      .waddr_i (wptr_q),
      .wdata_i (up_if.data),
      .raddr_i (rptr_q),
      .rdata_o (head)
   );

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (store) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
         rptr_d = rptr_q + 1'b1;
      end
      unique case ({store, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      in_err_d = push && bad_in;
      err_inc  = {1'b0, push && bad_in} + {1'b0, pop && bad_out};
      err_sum  = {1'b0, err_q}
               + {{(ERR_CNT_W-1){1'b0}}, err_inc};
      // The extra sum bit flags overflow; clamp instead of wrapping.
      err_d    = err_sum[ERR_CNT_W] ? ERR_MAX
                                    : err_sum[ERR_CNT_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         in_err_q <= 1'b0;
         err_q    <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         in_err_q <= in_err_d;
         err_q    <= err_d;
      end
   end

   assign par_err_out  = bad_out;
   assign in_err       = in_err_q;
   assign count        = count_q;
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign err_cnt      = err_q;

endmodule

// File: tb/tb_parity_fifo.sv
// Directed bench: instance a keeps bad words, instance b drops them.
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_parity_fifo;

   localparam int W = 17;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] din;
   logic         va, vb, ga, gb;

   logic         a_perr, a_inerr, a_af, a_ae;
   logic [4:0]   a_cnt;
   logic [7:0]   a_err;
   logic         b_perr, b_inerr, b_af, b_ae;
   logic [4:0]   b_cnt;
   logic [7:0]   b_err;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q [$];
   logic [W-1:0] e;

   parity_fifo_if #(.DATA_WIDTH(W)) a_up ();
   parity_fifo_if #(.DATA_WIDTH(W)) a_dn ();
   parity_fifo_if #(.DATA_WIDTH(W)) b_up ();
   parity_fifo_if #(.DATA_WIDTH(W)) b_dn ();

   assign a_up.data  = din;
   assign a_up.valid = va;
   assign a_dn.grant = ga;
   assign b_up.data  = din;
   assign b_up.valid = vb;
   assign b_dn.grant = gb;

   parity_fifo #(
      .DATA_WIDTH (W),
      .DEPTH      (16),
      .PARITY_ODD (1'b0),
      .DROP_BAD   (1'b0),
      .AF_LEVEL   (14),
      .AE_LEVEL   (2),
      .ERR_CNT_W  (8)
   ) u_a (
      .clk          (clk),
      .rst          (rst),
      .up_if        (a_up),
      .dn_if        (a_dn),
      .par_err_out  (a_perr),
      .in_err       (a_inerr),
      .count        (a_cnt),
      .almost_full  (a_af),
      .almost_empty (a_ae),
      .err_cnt      (a_err)
   );

   parity_fifo #(
      .DATA_WIDTH (W),
      .DEPTH      (16),
      .PARITY_ODD (1'b0),
      .DROP_BAD   (1'b1),
      .AF_LEVEL   (14),
      .AE_LEVEL   (2),
      .ERR_CNT_W  (8)
   ) u_b (
      .clk          (clk),
      .rst          (rst),
      .up_if        (b_up),
      .dn_if        (b_dn),
      .par_err_out  (b_perr),
      .in_err       (b_inerr),
      .count        (b_cnt),
      .almost_full  (b_af),
      .almost_empty (b_ae),
      .err_cnt      (b_err)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] good_w(input logic [15:0] v);
      return {^v, v};
   endfunction

   function automatic logic [W-1:0] bad_w(input logic [15:0] v);
      return {~(^v), v};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      din = '0;
      va  = 1'b0;
      vb  = 1'b0;
      ga  = 1'b0;
      gb  = 1'b0;
      #3;
      chk("rst_count", 32'(a_cnt), 0);
      chk("rst_valid", 32'(a_dn.valid), 0);
      chk("rst_grant", 32'(a_up.grant), 1);
      chk("rst_inerr", 32'(a_inerr), 0);
      chk("rst_err", 32'(a_err), 0);
      chk("rst_ae", 32'(a_ae), 1);
      chk("rst_af", 32'(a_af), 0);
      chk("rst_b_count", 32'(b_cnt), 0);
      step();
      rst = 1'b0;
      step();
      chk("idle_grant", 32'(a_up.grant), 1);

      // fill to full with no downstream grant
      va = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         din = good_w(16'(i));
         step();
         exp_q.push_back(good_w(16'(i)));
         if (i == 15) chk("grant_at15", 32'(a_up.grant), 1);
      end
      va = 1'b0;
      chk("full_grant", 32'(a_up.grant), 0);
      chk("full_count", 32'(a_cnt), 16);
      chk("full_af", 32'(a_af), 1);
      chk("full_ae", 32'(a_ae), 0);
      chk("full_valid", 32'(a_dn.valid), 1);

      // push attempt while full is refused; the pop proceeds
      va  = 1'b1;
      din = good_w(16'h7777);
      ga  = 1'b1;
      chk("pop_data", 32'(a_dn.data), 32'(exp_q[0]));
      step();
      void'(exp_q.pop_front());
      va = 1'b0;
      chk("full_pp_count", 32'(a_cnt), 15);
      chk("full_pp_grant", 32'(a_up.grant), 1);
      for (int i = 0; i < 15; i++) begin
         e = exp_q.pop_front();
         chk("pop_valid", 32'(a_dn.valid), 1);
         chk("pop_data", 32'(a_dn.data), 32'(e));
         step();
      end
      ga = 1'b0;
      chk("drain_valid", 32'(a_dn.valid), 0);
      chk("drain_count", 32'(a_cnt), 0);
      chk("drain_ae", 32'(a_ae), 1);

      // sustained push+pop at count 5
      va = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = good_w(16'h0100 + 16'(i));
         step();
         exp_q.push_back(good_w(16'h0100 + 16'(i)));
      end
      chk("pp_start_count", 32'(a_cnt), 5);
      ga = 1'b1;
      for (int i = 0; i < 100; i++) begin
         din = good_w(16'h0200 + 16'(i));
         chk("pp_data", 32'(a_dn.data), 32'(exp_q[0]));
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(good_w(16'h0200 + 16'(i)));
         chk("pp_count", 32'(a_cnt), 5);
      end
      va = 1'b0;
      chk("pp_err", 32'(a_err), 0);
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         chk("pp_drain", 32'(a_dn.data), 32'(e));
         step();
      end
      ga = 1'b0;
      chk("pp_empty", 32'(a_dn.valid), 0);

      // drop mode: bad word between two good words
      vb  = 1'b1;
      din = good_w(16'h0AAA);
      step();
      chk("drop_inerr0", 32'(b_inerr), 0);
      din = bad_w(16'h0BBB);
      step();
      chk("drop_inerr1", 32'(b_inerr), 1);
      chk("drop_cnt1", 32'(b_cnt), 1);
      chk("drop_grant", 32'(b_up.grant), 1);
      din = good_w(16'h0CCC);
      step();
      vb = 1'b0;
      chk("drop_inerr2", 32'(b_inerr), 0);
      chk("drop_cnt2", 32'(b_cnt), 2);
      chk("drop_err", 32'(b_err), 1);
      gb = 1'b1;
      chk("drop_head0", 32'(b_dn.data), 32'(good_w(16'h0AAA)));
      chk("drop_perr0", 32'(b_perr), 0);
      step();
      chk("drop_head1", 32'(b_dn.data), 32'(good_w(16'h0CCC)));
      step();
      gb = 1'b0;
      chk("drop_empty", 32'(b_dn.valid), 0);
      chk("drop_err_end", 32'(b_err), 1);

      // keep mode: bad word stored, flagged at head
      va  = 1'b1;
      din = bad_w(16'h0123);
      step();
      va = 1'b0;
      chk("keep_inerr", 32'(a_inerr), 1);
      chk("keep_err1", 32'(a_err), 1);
      chk("keep_cnt", 32'(a_cnt), 1);
      chk("keep_valid", 32'(a_dn.valid), 1);
      chk("keep_data", 32'(a_dn.data), 32'(bad_w(16'h0123)));
      chk("keep_perr", 32'(a_perr), 1);
      step();
      chk("keep_pulse", 32'(a_inerr), 0);
      ga = 1'b1;
      step();
      ga = 1'b0;
      chk("keep_err2", 32'(a_err), 2);
      chk("keep_cnt0", 32'(a_cnt), 0);
      chk("keep_perr0", 32'(a_perr), 0);

      // error counter saturation
      va = 1'b1;
      ga = 1'b1;
      for (int k = 1; k <= 300; k++) begin
         din = bad_w(16'(k));
         step();
         if (k == 10)  chk("sat_k10", 32'(a_err), 21);
         if (k == 126) chk("sat_k126", 32'(a_err), 253);
         if (k == 127) chk("sat_k127", 32'(a_err), 255);
         if (k == 128) chk("sat_k128", 32'(a_err), 255);
      end
      va = 1'b0;
      chk("sat_end", 32'(a_err), 255);
      chk("sat_cnt", 32'(a_cnt), 1);
      step();
      ga = 1'b0;
      chk("sat_hold", 32'(a_err), 255);
      chk("sat_cnt0", 32'(a_cnt), 0);

      // asynchronous reset with 9 entries held
      va = 1'b1;
      for (int i = 0; i < 9; i++) begin
         din = good_w(16'h0300 + 16'(i));
         step();
      end
      va = 1'b0;
      chk("pre_rst_cnt", 32'(a_cnt), 9);
      chk("pre_rst_af", 32'(a_af), 0);
      chk("pre_rst_ae", 32'(a_ae), 0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_cnt", 32'(a_cnt), 0);
      chk("arst_valid", 32'(a_dn.valid), 0);
      chk("arst_grant", 32'(a_up.grant), 1);
      chk("arst_ae", 32'(a_ae), 1);
      chk("arst_err", 32'(a_err), 0);
      #1;
      rst = 1'b0;
      va  = 1'b1;
      din = good_w(16'h0ABC);
      step();
      va = 1'b0;
      chk("post_valid", 32'(a_dn.valid), 1);
      chk("post_data", 32'(a_dn.data), 32'(good_w(16'h0ABC)));
      chk("post_cnt", 32'(a_cnt), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/parity_fifo.md
# parity_fifo

Parametrised successor to the fixed 17-bit valid/grant FIFO. It is a synchronous FIFO of configurable width and depth with even/odd parity checking on both sides. Input parity is checked on write, with optional drop of bad words. Parity is re-checked on read, and the block provides almost-full/almost-empty thresholds and a saturating error counter. It sits between the traffic generator (upstream valid/grant) and the grant-driven consumer (downstream valid/grant), and drives the checker's observation points.

## Interface
- DATA_WIDTH, 17: word width including parity; bit DATA_WIDTH-1 is parity over bits DATA_WIDTH-2:0.
- DEPTH, 16: number of entries; power of 2, at least 4.
- PARITY_ODD, 0: 0 selects even parity (XOR of all DATA_WIDTH bits is 0); 1 selects odd parity.
- DROP_BAD, 0: 1 means an input word with bad parity is accepted but not stored.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL.
- ERR_CNT_W, 8: error counter width.

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  clock, all state on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  upstream word.
- valid_in  input  1  upstream word valid.
- grant_out  output  1  FIFO can accept; equals !full.
- data_out  output  DATA_WIDTH  head-of-FIFO word (first-word fall-through).
- valid_out  output  1  FIFO not empty.
- grant_in  input  1  downstream accepts data_out.
- par_err_out  output  1  data_out fails the parity check; qualified by valid_out.
- in_err  output  1  one-cycle registered pulse: the last accepted input word had bad parity.
- count  output  $clog2(DEPTH)+1  current occupancy.
- almost_full  output  1  threshold flag.
- almost_empty  output  1  threshold flag.
- err_cnt  output  ERR_CNT_W  saturating count of input and output parity errors.

## Operation
- A push occurs when valid_in && grant_out. A pop occurs when valid_out && grant_in. A word transfers only on the edge where its handshake holds.
- Input check: bad_in = ^data_in ^ PARITY_ODD.
  - If bad_in is 1 on a push and DROP_BAD=1: the word is discarded, the write pointer and count are unchanged, and grant_out is still honoured (the word is consumed).
  - If bad_in is 1 on a push and DROP_BAD=0: the word is stored unchanged.
- Output check: par_err_out = valid_out && (^data_out ^ PARITY_ODD). It is combinational from the head entry.
- Error counter:
  - Increments by 1 for each bad push and by 1 for each pop with par_err_out=1.
  - When both occur on the same edge it adds 2.
  - It saturates at 2^ERR_CNT_W-1 and never wraps.
- Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. count is tracked separately as $clog2(DEPTH)+1 bits.
- Simultaneous push and pop:
  - Non-empty FIFO: count is unchanged and both pointers advance.
  - Empty FIFO: only the push occurs, because valid_out=0 prevents a pop.
  - Full FIFO: grant_out=0, so no push; a pop still proceeds.
- A dropped bad word coinciding with a pop gives count-1.
- Full is count==DEPTH. Empty is count==0. grant_out and valid_out depend only on count, never combinationally on valid_in or grant_in.
- Reset values: count=0, pointers=0, valid_out=0, grant_out=1, in_err=0, err_cnt=0, almost_empty=1, almost_full=0.
  - data_out is don't-care while valid_out=0; the bench must not check it.
  - Reset mid-transfer discards all contents immediately (asynchronous); the first push after rst deasserts is accepted normally.

## Timing
- Latency from push to valid_out is 1 cycle: a word pushed at edge N is visible on data_out and valid_out after edge N.
- Throughput is one push and one pop per cycle sustained.
- count, almost_full, almost_empty, err_cnt and in_err update on the edge of the event.
- grant_out and valid_out follow count in the same cycle. They are registered-derived and have no input-to-output combinational path.
- par_err_out follows data_out in the same cycle.
- Reset assertion forces all outputs to their reset values without waiting for clk.

## Structure
- Package fifo_pkg holds:
  - function parity_ok(word, odd): parameterised by width through a let/param class or a max-width argument.
  - localparam rules: ADDR_W = $clog2(DEPTH), CNT_W = ADDR_W+1.
  - A DEPTH power-of-2 elaboration check.
- Sub-module parity_fifo_mem: DEPTH x DATA_WIDTH storage with a synchronous write port and an asynchronous read port addressed by the read pointer.
- All control stays in parity_fifo: pointers, count, flags, parity checks and the error counter.

## Test plan
- Reset, push 16 good words (0x00001..0x00010 with parity fixed), no grant_in -> grant_out=0 after the 16th push, count=16, almost_full=1; then grant_in=1 -> 16 words pop in order, valid_out=0 after the last.
- Push and pop every cycle for 100 cycles at count=5 -> count stays 5, data order preserved, err_cnt=0.
- DROP_BAD=1, push one bad-parity word between two good words -> in_err pulses once, count increases by 2, err_cnt=1, the bad word never appears on data_out.
- DROP_BAD=0, push one bad-parity word -> the word is stored; when it reaches the head, par_err_out=1; popping it gives err_cnt=2 (one input error plus one output error).
- Push 300 bad words with ERR_CNT_W=8 -> err_cnt saturates at 255.
- Fill to count=9, assert rst asynchronously mid-cycle -> count=0, valid_out=0, grant_out=1 immediately; the next push produces data_out equal to that word one cycle later.
